// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory between fetch (I) and load/store (D).
// Valid access acks 3 cycles after the grant and an address error acks 1 cycle after; the losing port waits with req held.
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             i_ack,
  output logic             i_err,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic             d_err,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  state_t           state, state_nxt;
  logic             last_d, last_d_nxt;
  logic             req_d, req_we;
  logic             grant_d, load, addr_bad;
  logic             sel_we;
  logic [WIDTH-1:0] sel_addr, sel_wdata;
  logic             cs_nxt, ack_i_nxt, ack_d_nxt, err_nxt, cap;

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    load       = 1'b0;
    cs_nxt     = 1'b0;
    ack_i_nxt  = 1'b0;
    ack_d_nxt  = 1'b0;
    err_nxt    = 1'b0;
    cap        = 1'b0;
    // On a tie, the port not granted last time wins.
    grant_d    = d_req && (!i_req || !last_d);
    sel_we     = grant_d ? d_we    : i_we;
    sel_addr   = grant_d ? d_addr  : i_addr;
    sel_wdata  = grant_d ? d_wdata : i_wdata;
    addr_bad   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> 2) >= DEPTH_W);
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          load       = 1'b1;
          last_d_nxt = grant_d;
          if (addr_bad) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
            ack_i_nxt = !grant_d;
            ack_d_nxt = grant_d;
          end else begin
            state_nxt = ACCESS;
            cs_nxt    = 1'b1;
          end
        end
      end
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: begin
        state_nxt = DONE;
        cap       = !req_we;
        ack_i_nxt = !req_d;
        ack_d_nxt = req_d;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      req_d     <= 1'b0;
      req_we    <= 1'b0;
      busy      <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      busy   <= (state_nxt != IDLE);
      mem_cs <= cs_nxt;
      if (load) begin
        req_d  <= grant_d;
        req_we <= sel_we;
      end
      // Memory pins only move for an accepted access; cs alone qualifies them.
      if (cs_nxt) begin
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      i_ack <= ack_i_nxt;
      d_ack <= ack_d_nxt;
      i_err <= ack_i_nxt & err_nxt;
      d_err <= ack_d_nxt & err_nxt;
      if (cap && !req_d) i_rdata <= mem_rdata;
      if (cap && req_d)  d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, transaction-level reference model checked every cycle, directed scenarios.
module tb_mem_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_req, i_we, d_req, d_we;
  logic [WIDTH-1:0] i_addr, i_wdata, d_addr, d_wdata;
  logic             i_ack, i_err, d_ack, d_err;
  logic [WIDTH-1:0] i_rdata, d_rdata;
  logic             mem_cs, mem_we;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory device: registered output, high-Z after a cycle without cs.
  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] mem_q;
  assign mem_rdata = mem_q;

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      else        mem_q <= mem[mem_addr[11:2]];
    end else begin
      mem_q <= 'z;
    end
  end

  // Reference model: whole transactions, a busy countdown and a separate memory image.
  bit          m_on = 0;
  int          m_cnt;
  bit          m_last_d, m_port_d, m_we;
  logic [31:0] m_rd;
  logic        exp_cs, exp_we, exp_i_ack, exp_d_ack, exp_err, exp_busy;
  logic [31:0] exp_addr, exp_wdata, exp_i_rdata, exp_d_rdata;

  always @(posedge clk) begin
    bit          g;
    logic [31:0] a, wd;
    logic        we;
    if (!rst_n) begin
      m_on = 1; m_cnt = 0; m_last_d = 0;
      exp_cs = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
      exp_i_ack = 0; exp_d_ack = 0; exp_err = 0; exp_busy = 0;
      exp_i_rdata = 0; exp_d_rdata = 0;
    end else if (m_on) begin
      exp_cs = 0; exp_i_ack = 0; exp_d_ack = 0; exp_err = 0;
      if (m_cnt == 0) begin
        if (i_req || d_req) begin
          g  = (i_req && d_req) ? !m_last_d : d_req;
          m_last_d = g;
          m_port_d = g;
          a  = g ? d_addr : i_addr;
          wd = g ? d_wdata : i_wdata;
          we = g ? d_we : i_we;
          m_we = we;
          if (a[1:0] != 2'b00 || (a / 4) >= DEPTH) begin
            m_cnt = 1;
            exp_err = 1;
            if (g) exp_d_ack = 1; else exp_i_ack = 1;
          end else begin
            m_cnt = 3;
            exp_cs = 1; exp_we = we; exp_addr = a; exp_wdata = wd;
            if (we) ref_mem[a[11:2]] = wd;
            else    m_rd = ref_mem[a[11:2]];
          end
        end
      end else begin
        m_cnt--;
        if (m_cnt == 1) begin
          if (m_port_d) exp_d_ack = 1; else exp_i_ack = 1;
          if (!m_we) begin
            if (m_port_d) exp_d_rdata = m_rd; else exp_i_rdata = m_rd;
          end
        end
      end
      exp_busy = (m_cnt != 0);
    end
  end

  int          cs_cnt, i_ack_cnt, d_ack_cnt;
  logic        last_cs_we;
  logic [31:0] last_cs_addr;

  always @(negedge clk) begin
    if (m_on) begin
      chk("busy", busy, exp_busy);
      chk("mem_cs", mem_cs, exp_cs);
      if (exp_cs) begin
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("i_ack", i_ack, exp_i_ack);
      chk("d_ack", d_ack, exp_d_ack);
      if (exp_i_ack) chk("i_err", i_err, exp_err);
      if (exp_d_ack) chk("d_err", d_err, exp_err);
      chk("i_rdata", i_rdata, exp_i_rdata);
      chk("d_rdata", d_rdata, exp_d_rdata);
    end
    if (mem_cs) begin
      cs_cnt++;
      last_cs_we = mem_we;
      last_cs_addr = mem_addr;
    end
    if (i_ack) i_ack_cnt++;
    if (d_ack) d_ack_cnt++;
  end

  task automatic clr_cnt();
    cs_cnt = 0; i_ack_cnt = 0; d_ack_cnt = 0;
  endtask

  // One request on one port; returns cycles from grant sample to ack and err seen with ack.
  task automatic do_access(input bit pd, input bit we, input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic err);
    lat = 0;
    err = 1'bx;
    if (pd) begin d_we = we; d_addr = a; d_wdata = wd; d_req = 1; end
    else    begin i_we = we; i_addr = a; i_wdata = wd; i_req = 1; end
    while (lat <= 20) begin
      @(posedge clk); #1;
      lat++;
      if (pd && d_ack) begin err = d_err; break; end
      if (!pd && i_ack) begin err = i_err; break; end
    end
    i_req = 0; d_req = 0;
    @(posedge clk); #1;
  endtask

  int          lat;
  logic        err;
  int          rr_port [4];
  int          rr_time [4];
  int          nack, cyc;

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = 32'hA500_0000 | k;
      ref_mem[k] = 32'hA500_0000 | k;
    end
    mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    rst_n = 0; i_req = 0; d_req = 0; i_we = 0; d_we = 0;
    i_addr = 0; d_addr = 0; i_wdata = 0; d_wdata = 0;
    clr_cnt();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_errs", {i_err, d_err}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Single D read of word 4
    clr_cnt();
    do_access(1, 0, 32'h10, 0, lat, err);
    chk("dread_lat", lat, 3);
    chk("dread_err", err, 0);
    chk("dread_data", d_rdata, 32'hDEAD_BEEF);
    chk("dread_cs_cycles", cs_cnt, 1);
    chk("dread_cs_addr", last_cs_addr, 32'h10);
    chk("dread_cs_we", last_cs_we, 0);
    chk("dread_no_iack", i_ack_cnt, 0);

    // D write then I read back
    clr_cnt();
    do_access(1, 1, 32'h20, 32'h1234_5678, lat, err);
    chk("dwrite_lat", lat, 3);
    chk("dwrite_err", err, 0);
    chk("dwrite_cs_cycles", cs_cnt, 1);
    chk("dwrite_cs_we", last_cs_we, 1);
    do_access(0, 0, 32'h20, 0, lat, err);
    chk("iread_lat", lat, 3);
    chk("iread_data", i_rdata, 32'h1234_5678);
    chk("iread_d_kept", d_rdata, 32'hDEAD_BEEF);

    // Both ports requesting continuously
    for (int k = 0; k < 4; k++) begin rr_port[k] = -1; rr_time[k] = -1; end
    i_we = 0; d_we = 0; i_addr = 32'h20; d_addr = 32'h10;
    i_req = 1; d_req = 1;
    nack = 0; cyc = 0;
    while (nack < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (d_ack) begin rr_port[nack] = 1; rr_time[nack] = cyc; nack++; end
      else if (i_ack) begin rr_port[nack] = 0; rr_time[nack] = cyc; nack++; end
    end
    i_req = 0; d_req = 0;
    @(posedge clk); #1;
    chk("rr_g0_port", rr_port[0], 1);
    chk("rr_g1_port", rr_port[1], 0);
    chk("rr_g2_port", rr_port[2], 1);
    chk("rr_g3_port", rr_port[3], 0);
    chk("rr_g0_time", rr_time[0], 3);
    chk("rr_g1_time", rr_time[1], 7);
    chk("rr_g2_time", rr_time[2], 11);
    chk("rr_g3_time", rr_time[3], 15);

    // Rejected and boundary addresses
    clr_cnt();
    do_access(1, 0, 32'h0000_0002, 0, lat, err);
    chk("misalign_lat", lat, 1);
    chk("misalign_err", err, 1);
    do_access(1, 1, 32'(4 * DEPTH), 32'hFFFF_FFFF, lat, err);
    chk("range_lat", lat, 1);
    chk("range_err", err, 1);
    chk("reject_no_cs", cs_cnt, 0);
    do_access(0, 0, 32'(4 * DEPTH - 4), 0, lat, err);
    chk("top_word_lat", lat, 3);
    chk("top_word_err", err, 0);
    chk("top_word_data", i_rdata, 32'hA500_03FF);

    // Reset during CAPTURE of an I read
    clr_cnt();
    i_we = 0; i_addr = 32'h20; i_req = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 0; i_req = 0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_cs", mem_cs, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_i_rdata", i_rdata, 0);
    chk("abort_d_rdata", d_rdata, 0);
    rst_n = 1;
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_no_iack", i_ack_cnt, 0);
    do_access(1, 0, 32'h10, 0, lat, err);
    chk("post_abort_lat", lat, 3);
    chk("post_abort_data", d_rdata, 32'hDEAD_BEEF);

    // Idle bus
    clr_cnt();
    repeat (20) begin @(posedge clk); #1; end
    chk("idle_cs", cs_cnt, 0);
    chk("idle_acks", i_ack_cnt + d_ack_cnt, 0);
    chk("idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported word memory between the instruction-fetch unit (port I) and the load/store unit (port D) of the MIPS core. Each requester uses a level req / one-cycle ack handshake. The arbiter grants one access at a time with round-robin priority and drives the memory's cs/we/addr/data pins from registers. It captures read data from the memory's registered, tri-stated output and rejects misaligned or out-of-range addresses without touching memory.

## Interface
- WIDTH, 32: data and address width.
- DEPTH, 1024: memory size in words. Valid word index is 0..DEPTH-1.

- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_req  in  1  instruction-port request, held high until i_ack.
- i_we  in  1  instruction-port write enable (normally 0).
- i_addr  in  WIDTH  instruction-port byte address.
- i_wdata  in  WIDTH  instruction-port write data.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  valid with i_ack: request rejected.
- i_rdata  out  WIDTH  read data, valid with i_ack, held until the next port-I read completes.
- d_req, d_we, d_addr, d_wdata, d_ack, d_err, d_rdata: same as the I port, for port D.
- mem_cs  out  1  memory chip select.
- mem_we  out  1  memory write enable.
- mem_addr  out  WIDTH  memory byte address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory data_o. It is high-Z when cs was low at the previous edge.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- **IDLE**
  - If neither req is high: stay.
  - If exactly one req is high: grant that port.
  - If both are high: grant the port not granted last. The last-grant pointer resets to I, so D wins the first tie.
  - At the grant, latch the port id, we, addr and wdata into an internal request register, and update the pointer.
  - Check the latched addr. If addr[1:0] != 0 or (addr>>2) >= DEPTH, go to DONE with err=1 and do not drive the memory. Otherwise go to ACCESS.
- **ACCESS**
  - mem_cs=1, mem_we=latched we, mem_addr and mem_wdata from the request register.
  - Memory samples these at the end of this cycle.
  - Next state: CAPTURE.
- **CAPTURE**
  - mem_cs=0.
  - For a read, register mem_rdata into the granted port's rdata register at the end of this cycle.
  - For a write, the rdata registers are unchanged.
  - Next state: DONE.
- **DONE**
  - Pulse the granted port's ack for exactly one cycle. err is valid with it.
  - Next state is always IDLE. A requester's req sampled in that IDLE is treated as a new request.
- Requesters must hold we/addr/wdata stable while req is high. The arbiter samples them only in IDLE.
- The non-granted port waits with req high. It gets no ack and its rdata is unchanged.
- mem_addr/mem_wdata/mem_we hold their last values when mem_cs=0. Only mem_cs qualifies them.

## Timing
- Reset (rst_n low at a rising edge):
  - state=IDLE, pointer=I.
  - mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - i_ack=d_ack=0, i_err=d_err=0, i_rdata=d_rdata=0, busy=0.
- Reset asserted mid-access aborts it. No ack is ever issued for the aborted request. A write already sampled by memory in ACCESS is not undone.
- Normal access, with req sampled high in IDLE at cycle t:
  - t+1: ACCESS, mem_cs=1.
  - t+2: CAPTURE.
  - t+3: DONE, ack=1 and rdata valid.
  - t+4: IDLE.
- Minimum spacing between grants is 4 cycles.
- Error access: req sampled in IDLE at t gives DONE at t+1 with ack=1 and err=1. mem_cs stays 0.
- All outputs are registered. None depends combinationally on the inputs.
- Worst-case wait for a continuously requesting port is one foreign access, 4 cycles, plus its own 4 cycles.

## Test plan
- Reset, then a single D read with d_addr=0x10 (memory word 4 = 0xDEADBEEF):
  - mem_cs high exactly 1 cycle with mem_addr=0x10 and mem_we=0.
  - d_ack pulses at t+3 with d_rdata=0xDEADBEEF and d_err=0.
  - i_ack stays 0.
- D write 0x12345678 to 0x20, then I read from 0x20:
  - Write: one cs cycle with mem_we=1, then d_ack with d_err=0.
  - Read: i_rdata=0x12345678, and d_rdata is unchanged.
- i_req and d_req both held high continuously:
  - Grants alternate D, I, D, I.
  - Acks are 4 cycles apart, and each port is acked every 8 cycles.
- Rejected addresses:
  - d_addr=0x0000_0002 gives d_ack and d_err at t+1, with mem_cs never asserted.
  - d_addr=4*DEPTH gives the same result.
- Reset in the middle of an access: rst_n pulsed low during the CAPTURE cycle of an I read. No i_ack follows, all outputs return to their reset values, and the next request completes normally.
- Idle bus: with no requests for 20 cycles, mem_cs=0, busy=0, and all acks stay 0.
